multicycle_control: RTL and testbench

- Moore/Mealy FSM that sequences the shared multicycle MIPS-subset datapath: single memory for instructions and data, one ALU, IR, A/B/ALUOut registers.
- Replaces single-cycle op decoding with per-state control over 3–5 cycles per instruction.
- Stalls on a memory-ready handshake, flags illegal opcodes, and counts retired instructions.
- Sits between the IR opcode field and every datapath enable and mux select.

---
 rtl/multicycle_control_if.sv | 31 +++
 rtl/multicycle_control.sv | 165 ++++++++++++++++
 tb/tb_multicycle_control.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle sequencer and the shared datapath:
// the IR opcode and memory handshake in, every enable and mux select out.
interface multicycle_control_if;
  logic [5:0] op;
  logic       mem_ready;
  logic       PCWrite;
  logic       Branch;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemToReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic [1:0] PCSrc;

  modport master (
    input  op, mem_ready,
    output PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, MemToReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc
  );

  modport slave (
    output op, mem_ready,
    input  PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, MemToReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control FSM: per-state datapath controls decoded from
// the state register, memory-ready stalls, illegal-opcode flag, retire counter.
module multicycle_control #(
  parameter int unsigned CNT_WIDTH        = 32,
  parameter bit          IDLE_AFTER_RESET = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  multicycle_control_if.master     bus,
  output logic                     illegal_op,
  output logic [CNT_WIDTH-1:0]     instr_count,
  output logic [3:0]               state
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD  = 4'd4;
  localparam logic [3:0] S_MEMWB  = 4'd5;
  localparam logic [3:0] S_MEMWR  = 4'd6;
  localparam logic [3:0] S_EXEC   = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_ADDIEX = 4'd10;
  localparam logic [3:0] S_ADDIWB = 4'd11;
  localparam logic [3:0] S_JUMP   = 4'd12;

  localparam logic [3:0] S_RESET = IDLE_AFTER_RESET ? S_IDLE : S_FETCH;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic [3:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] instr_count_q, instr_count_d;
  logic                 retire_c;

  // Controls are a pure decode of state (plus mem_ready in FETCH), so an
  // asynchronous reset clears every strobe in the same cycle.
  always_comb begin
    state_d      = state_q;
    retire_c     = 1'b0;
    illegal_op   = 1'b0;
    bus.PCWrite  = 1'b0;
    bus.Branch   = 1'b0;
    bus.IorD     = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.MemToReg = 1'b0;
    bus.RegDst   = 1'b0;
    bus.RegWrite = 1'b0;
    bus.ALUSrcA  = 1'b0;
    bus.ALUSrcB  = 2'b00;
    bus.ALUOp    = 3'b000;
    bus.PCSrc    = 2'b00;

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        if (bus.mem_ready) begin
          bus.IRWrite = 1'b1;
          bus.PCWrite = 1'b1;
          state_d     = S_DECODE;
        end
      end
      S_DECODE: begin
        bus.ALUSrcB = 2'b11;
        case (bus.op)
          OP_R:         state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        state_d     = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        bus.RegWrite = 1'b1;
        bus.MemToReg = 1'b1;
        retire_c     = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
        if (bus.mem_ready) begin
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 3'b010;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 1'b1;
        retire_c     = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 3'b001;
        bus.Branch  = 1'b1;
        bus.PCSrc   = 2'b01;
        retire_c    = 1'b1;
        state_d     = S_FETCH;
      end
      S_ADDIEX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        state_d     = S_ADDIWB;
      end
      S_ADDIWB: begin
        bus.RegWrite = 1'b1;
        retire_c     = 1'b1;
        state_d      = S_FETCH;
      end
      S_JUMP: begin
        bus.PCWrite = 1'b1;
        bus.PCSrc   = 2'b10;
        retire_c    = 1'b1;
        state_d     = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    instr_count_d = retire_c ? instr_count_q + CNT_WIDTH'(1) : instr_count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_RESET;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign state       = state_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: two instances (default parameters, and
// 2-bit counter starting in FETCH) walked through hand-computed state/control tables.
module tb_multicycle_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0_n, rst1_n;
  logic        ill0, ill1;
  logic [31:0] cnt0;
  logic [1:0]  cnt1;
  logic [3:0]  st0, st1;
  int          total = 0;
  int          bad   = 0;

  multicycle_control_if bus0 ();
  multicycle_control_if bus1 ();

  multicycle_control #(.CNT_WIDTH(32), .IDLE_AFTER_RESET(1'b1)) dut0 (
    .clk(clk), .rst_n(rst0_n), .bus(bus0.master),
    .illegal_op(ill0), .instr_count(cnt0), .state(st0));

  multicycle_control #(.CNT_WIDTH(2), .IDLE_AFTER_RESET(1'b0)) dut1 (
    .clk(clk), .rst_n(rst1_n), .bus(bus1.master),
    .illegal_op(ill1), .instr_count(cnt1), .state(st1));

  // {PCWrite,Branch,IorD,MemRead,MemWrite,IRWrite,MemToReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSrc}
  logic [16:0] ctrl0, ctrl1;
  assign ctrl0 = {bus0.PCWrite, bus0.Branch, bus0.IorD, bus0.MemRead, bus0.MemWrite,
                  bus0.IRWrite, bus0.MemToReg, bus0.RegDst, bus0.RegWrite, bus0.ALUSrcA,
                  bus0.ALUSrcB, bus0.ALUOp, bus0.PCSrc};
  assign ctrl1 = {bus1.PCWrite, bus1.Branch, bus1.IorD, bus1.MemRead, bus1.MemWrite,
                  bus1.IRWrite, bus1.MemToReg, bus1.RegDst, bus1.RegWrite, bus1.ALUSrcA,
                  bus1.ALUSrcB, bus1.ALUOp, bus1.PCSrc};

  localparam logic [16:0] C_ZERO   = 17'b0000000000_00_000_00;
  localparam logic [16:0] C_FWAIT  = 17'b0001000000_01_000_00;
  localparam logic [16:0] C_FGO    = 17'b1001010000_01_000_00;
  localparam logic [16:0] C_DECODE = 17'b0000000000_11_000_00;
  localparam logic [16:0] C_MEMADR = 17'b0000000001_10_000_00;
  localparam logic [16:0] C_MEMRD  = 17'b0011000000_00_000_00;
  localparam logic [16:0] C_MEMWB  = 17'b0000001010_00_000_00;
  localparam logic [16:0] C_MEMWR  = 17'b0010100000_00_000_00;
  localparam logic [16:0] C_EXEC   = 17'b0000000001_00_010_00;
  localparam logic [16:0] C_ALUWB  = 17'b0000000110_00_000_00;
  localparam logic [16:0] C_BRANCH = 17'b0100000001_00_001_01;
  localparam logic [16:0] C_ADDIEX = 17'b0000000001_10_000_00;
  localparam logic [16:0] C_ADDIWB = 17'b0000000010_00_000_00;
  localparam logic [16:0] C_JUMP   = 17'b1000000000_00_000_10;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive op/mem_ready in the low phase, then check state and controls.
  task automatic cyc(input int d, input logic [5:0] o, input logic mr,
                     input logic [3:0] es, input logic [16:0] ec, input string tag);
    @(negedge clk);
    if (d == 0) begin bus0.op = o; bus0.mem_ready = mr; end
    else        begin bus1.op = o; bus1.mem_ready = mr; end
    #1;
    chk({tag, ".state"}, (d == 0) ? 32'(st0) : 32'(st1), 32'(es));
    chk({tag, ".ctrl"},  (d == 0) ? 32'(ctrl0) : 32'(ctrl1), 32'(ec));
  endtask

  initial begin
    rst0_n = 1'b0; rst1_n = 1'b0;
    bus0.op = OP_R; bus0.mem_ready = 1'b1;
    bus1.op = OP_J; bus1.mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst0.state", 32'(st0), 32'd0);
    chk("rst0.ctrl", 32'(ctrl0), 32'(C_ZERO));
    chk("rst0.cnt", cnt0, 32'd0);
    chk("rst0.ill", 32'(ill0), 32'd0);
    chk("rst1.state", 32'(st1), 32'd1);
    chk("rst1.ctrl", 32'(ctrl1), 32'(C_FWAIT));

    // Release: one IDLE cycle (mem_ready ignored), then FETCH.
    @(negedge clk); rst0_n = 1'b1; #1;
    chk("idle.state", 32'(st0), 32'd0);
    chk("idle.ctrl", 32'(ctrl0), 32'(C_ZERO));

    // R-type: 1,2,7,8
    cyc(0, OP_R, 1'b1, 4'd1, C_FGO,    "r.fetch");
    cyc(0, OP_R, 1'b1, 4'd2, C_DECODE, "r.decode");
    cyc(0, OP_R, 1'b1, 4'd7, C_EXEC,   "r.exec");
    cyc(0, OP_R, 1'b1, 4'd8, C_ALUWB,  "r.aluwb");
    chk("r.cnt_before", cnt0, 32'd0);

    // LW with 3 FETCH stalls and 2 MEMRD stalls: 10 cycles.
    cyc(0, OP_LW, 1'b0, 4'd1, C_FWAIT, "lw.fwait0");
    chk("r.cnt_after", cnt0, 32'd1);
    cyc(0, OP_LW, 1'b0, 4'd1, C_FWAIT,  "lw.fwait1");
    cyc(0, OP_LW, 1'b0, 4'd1, C_FWAIT,  "lw.fwait2");
    cyc(0, OP_LW, 1'b1, 4'd1, C_FGO,    "lw.fetch");
    cyc(0, OP_LW, 1'b0, 4'd2, C_DECODE, "lw.decode");
    cyc(0, OP_LW, 1'b0, 4'd3, C_MEMADR, "lw.memadr");
    cyc(0, OP_LW, 1'b0, 4'd4, C_MEMRD,  "lw.mrwait0");
    cyc(0, OP_LW, 1'b0, 4'd4, C_MEMRD,  "lw.mrwait1");
    cyc(0, OP_LW, 1'b1, 4'd4, C_MEMRD,  "lw.memrd");
    cyc(0, OP_LW, 1'b0, 4'd5, C_MEMWB,  "lw.memwb");
    chk("lw.cnt_before", cnt0, 32'd1);

    // SW, BEQ, J back to back.
    cyc(0, OP_SW, 1'b1, 4'd1, C_FGO,    "sw.fetch");
    chk("lw.cnt_after", cnt0, 32'd2);
    cyc(0, OP_SW, 1'b1, 4'd2, C_DECODE, "sw.decode");
    cyc(0, OP_SW, 1'b1, 4'd3, C_MEMADR, "sw.memadr");
    cyc(0, OP_SW, 1'b1, 4'd6, C_MEMWR,  "sw.memwr");
    cyc(0, OP_BEQ, 1'b1, 4'd1, C_FGO,    "beq.fetch");
    cyc(0, OP_BEQ, 1'b1, 4'd2, C_DECODE, "beq.decode");
    cyc(0, OP_BEQ, 1'b1, 4'd9, C_BRANCH, "beq.branch");
    cyc(0, OP_J, 1'b1, 4'd1,  C_FGO,    "j.fetch");
    cyc(0, OP_J, 1'b1, 4'd2,  C_DECODE, "j.decode");
    cyc(0, OP_J, 1'b1, 4'd12, C_JUMP,   "j.jump");
    chk("j.cnt_before", cnt0, 32'd4);

    // Illegal opcode: one-cycle pulse in DECODE, back to FETCH, no retire.
    cyc(0, OP_BAD, 1'b1, 4'd1, C_FGO, "bad.fetch");
    chk("j.cnt_after", cnt0, 32'd5);
    chk("bad.ill_fetch", 32'(ill0), 32'd0);
    cyc(0, OP_BAD, 1'b1, 4'd2, C_DECODE, "bad.decode");
    chk("bad.ill_decode", 32'(ill0), 32'd1);
    cyc(0, OP_LW, 1'b1, 4'd1, C_FGO, "bad.refetch");
    chk("bad.ill_after", 32'(ill0), 32'd0);
    chk("bad.cnt", cnt0, 32'd5);

    // LW aborted by reset while stalled in MEMRD.
    cyc(0, OP_LW, 1'b0, 4'd2, C_DECODE, "abort.decode");
    cyc(0, OP_LW, 1'b0, 4'd3, C_MEMADR, "abort.memadr");
    cyc(0, OP_LW, 1'b0, 4'd4, C_MEMRD,  "abort.memrd");
    rst0_n = 1'b0; #1;
    chk("abort.state", 32'(st0), 32'd0);
    chk("abort.ctrl", 32'(ctrl0), 32'(C_ZERO));
    chk("abort.cnt", cnt0, 32'd0);
    @(negedge clk); rst0_n = 1'b1; #1;
    chk("abort.idle", 32'(st0), 32'd0);
    cyc(0, OP_LW, 1'b0, 4'd1, C_FWAIT, "abort.fetch");

    // Second instance: starts in FETCH, 2-bit counter wraps on the fourth retire.
    @(negedge clk); rst1_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1, OP_J, 1'b1, 4'd1,  C_FGO,    "w.j.fetch");
      cyc(1, OP_J, 1'b1, 4'd2,  C_DECODE, "w.j.decode");
      cyc(1, OP_J, 1'b1, 4'd12, C_JUMP,   "w.j.jump");
    end
    cyc(1, OP_ADDI, 1'b1, 4'd1,  C_FGO,    "w.addi.fetch");
    chk("w.cnt_full", 32'(cnt1), 32'd3);
    cyc(1, OP_ADDI, 1'b1, 4'd2,  C_DECODE, "w.addi.decode");
    cyc(1, OP_ADDI, 1'b1, 4'd10, C_ADDIEX, "w.addi.ex");
    cyc(1, OP_ADDI, 1'b1, 4'd11, C_ADDIWB, "w.addi.wb");
    cyc(1, OP_SW, 1'b1, 4'd1, C_FGO, "w.sw.fetch");
    chk("w.cnt_wrap", 32'(cnt1), 32'd0);

    // SW aborted by reset while stalled in MEMWR: write strobe drops at once.
    cyc(1, OP_SW, 1'b0, 4'd2, C_DECODE, "w.sw.decode");
    cyc(1, OP_SW, 1'b0, 4'd3, C_MEMADR, "w.sw.memadr");
    cyc(1, OP_SW, 1'b0, 4'd6, C_MEMWR,  "w.sw.memwr");
    rst1_n = 1'b0; #1;
    chk("w.abort.state", 32'(st1), 32'd1);
    chk("w.abort.ctrl", 32'(ctrl1), 32'(C_FWAIT));
    chk("w.abort.cnt", 32'(cnt1), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
